// File: rtl/pc_adder_arbiter.sv
// Shared 16-bit adder with a round-robin arbiter. Requester 0 (the PC path)
// can optionally win every cycle, but only for a bounded number of cycles
// while another requester waits. The selected sum is registered together
// with the owner's index, so each result appears one cycle after its grant.
module pc_adder_arbiter #(
  parameter int WIDTH       = 16,
  parameter int NREQ        = 3,
  parameter int PC_PRIORITY = 1,
  parameter int MAX_WAIT    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_flat,
  input  logic [NREQ*WIDTH-1:0] b_flat,
  input  logic [NREQ-1:0]       cin,
  output logic [NREQ-1:0]       gnt,
  output logic                  res_valid,
  output logic [1:0]            res_id,
  output logic [WIDTH-1:0]      res_sum,
  output logic                  res_cout
);

  logic [1:0]      ptr;
  logic [3:0]      starve_cnt;
  logic            others;
  logic            starved;
  logic            pc_wins;
  logic [NREQ-1:0] elig;
  logic            found;
  int              idx;
  logic            xfer;
  logic [1:0]      gid;
  logic [1:0]      next_ptr;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic            cin_sel;
  logic [WIDTH-1:0] sum_c;
  logic            cout_c;

  assign others  = |req[NREQ-1:1];
  // starve_cnt saturates at MAX_WAIT, so "== MAX_WAIT" is the same as "not below it"
  assign starved = (PC_PRIORITY != 0) && (starve_cnt == 4'(MAX_WAIT));
  assign pc_wins = (PC_PRIORITY != 0) && req[0] && !starved;

  // Requester 0 sits out the rotating search once it has used its priority budget,
  // unless nobody else is asking.
  always_comb begin
    elig = req;
    if (starved && others) elig[0] = 1'b0;
  end

  // One-hot grant: PC priority first, else first eligible index starting at ptr
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    if (!reset) begin
      if (pc_wins) begin
        gnt[0] = 1'b1;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (int'(ptr) + k) % NREQ;
          if (!found && elig[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end
  end

  // AND-OR operand mux driven by the one-hot grant, plus the encoded winner index
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    gid     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel   = a_sel | a_flat[i*WIDTH +: WIDTH];
        b_sel   = b_sel | b_flat[i*WIDTH +: WIDTH];
        cin_sel = cin_sel | cin[i];
        gid     = gid | 2'(i);
      end
    end
  end

  assign {cout_c, sum_c} = {1'b0, a_sel} + {1'b0, b_sel} + (WIDTH+1)'(cin_sel);
  assign xfer            = |(req & gnt);
  assign next_ptr        = (gid == 2'(NREQ-1)) ? 2'd0 : gid + 2'd1;

  // Round-robin pointer and PC starvation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      starve_cnt <= '0;
    end else if (xfer) begin
      ptr <= next_ptr;
      if (PC_PRIORITY != 0) begin
        if (gnt[0] && others) begin
          if (!starved) starve_cnt <= starve_cnt + 4'd1;
        end else begin
          starve_cnt <= '0;
        end
      end
    end
  end

  // Result register: valid pulses per transfer, payload holds between transfers
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
    end else if (xfer) begin
      res_valid <= 1'b1;
      res_id    <= gid;
      res_sum   <= sum_c;
      res_cout  <= cout_c;
    end else begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_adder_arbiter.sv
// Bench for pc_adder_arbiter: one instance with PC priority (MAX_WAIT=3) and one
// pure round-robin instance, checked every cycle against a queue-free
// behavioural model plus directed literal expectations.
module tb_pc_adder_arbiter;

  localparam int MW = 3;
  localparam int PCP [2] = '{1, 0};

  logic clk = 1'b0;
  logic rst;
  logic chk_on = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  req    [2];
  logic [47:0] a_flat [2];
  logic [47:0] b_flat [2];
  logic [2:0]  cin    [2];
  logic [2:0]  gnt    [2];
  logic        rv     [2];
  logic [1:0]  rid    [2];
  logic [15:0] rsum   [2];
  logic        rcout  [2];

  pc_adder_arbiter #(.WIDTH(16), .NREQ(3), .PC_PRIORITY(1), .MAX_WAIT(MW)) u_pri (
    .clk(clk), .reset(rst), .req(req[0]), .a_flat(a_flat[0]), .b_flat(b_flat[0]),
    .cin(cin[0]), .gnt(gnt[0]), .res_valid(rv[0]), .res_id(rid[0]),
    .res_sum(rsum[0]), .res_cout(rcout[0]));

  pc_adder_arbiter #(.WIDTH(16), .NREQ(3), .PC_PRIORITY(0), .MAX_WAIT(MW)) u_rr (
    .clk(clk), .reset(rst), .req(req[1]), .a_flat(a_flat[1]), .b_flat(b_flat[1]),
    .cin(cin[1]), .gnt(gnt[1]), .res_valid(rv[1]), .res_id(rid[1]),
    .res_sum(rsum[1]), .res_cout(rcout[1]));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // Model: who went last, how many PC grants in a row beat a waiting requester,
  // and what the result register must hold.
  int          m_last   [2];
  int          m_streak [2];
  logic        m_rv     [2];
  logic [1:0]  m_rid    [2];
  logic [15:0] m_sum    [2];
  logic        m_cout   [2];

  task automatic model_reset(input int k);
    m_last[k]   = -1;
    m_streak[k] = 0;
    m_rv[k]     = 1'b0;
    m_rid[k]    = 2'd0;
    m_sum[k]    = 16'd0;
    m_cout[k]   = 1'b0;
  endtask

  function automatic int pick(input int k);
    logic oth;
    int   c;
    if (rst || req[k] == 3'b000) return -1;
    oth = |req[k][2:1];
    if (PCP[k] == 1 && req[k][0] && m_streak[k] < MW) return 0;
    for (int o = 1; o <= 3; o++) begin
      c = (m_last[k] + o) % 3;
      if (req[k][c] && !(c == 0 && PCP[k] == 1 && m_streak[k] >= MW && oth)) return c;
    end
    return -1;
  endfunction

  // Per-cycle compare against the model, then advance the model past the next edge
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        int w;
        logic [16:0] s;
        w = pick(k);
        chk($sformatf("m%0d_gnt", k), 32'(gnt[k]), (w < 0) ? 32'd0 : (32'd1 << w));
        chk($sformatf("m%0d_valid", k), 32'(rv[k]), 32'(m_rv[k]));
        chk($sformatf("m%0d_id", k), 32'(rid[k]), 32'(m_rid[k]));
        chk($sformatf("m%0d_sum", k), 32'(rsum[k]), 32'(m_sum[k]));
        chk($sformatf("m%0d_cout", k), 32'(rcout[k]), 32'(m_cout[k]));
        if (rst) begin
          model_reset(k);
        end else if (w >= 0) begin
          s = {1'b0, a_flat[k][w*16 +: 16]} + {1'b0, b_flat[k][w*16 +: 16]} + 17'(cin[k][w]);
          m_rv[k]   = 1'b1;
          m_rid[k]  = 2'(w);
          m_sum[k]  = s[15:0];
          m_cout[k] = s[16];
          if (w == 0 && (|req[k][2:1])) m_streak[k] = (m_streak[k] < MW) ? m_streak[k] + 1 : MW;
          else m_streak[k] = 0;
          m_last[k] = w;
        end else begin
          m_rv[k] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) req[k] = 3'b000;
    tick();
    rst = 1'b0;
  endtask

  int ord3 [6] = '{0, 1, 2, 0, 1, 2};
  int ord4 [8] = '{0, 0, 0, 2, 0, 0, 0, 2};

  initial begin
    for (int k = 0; k < 2; k++) begin
      req[k] = '0; a_flat[k] = '0; b_flat[k] = '0; cin[k] = '0;
      model_reset(k);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 chk_on = 1'b1;
    tick();
    rst = 1'b0;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_gnt", 32'(gnt[0]), 32'd0);
      chk("idle_valid", 32'(rv[0]), 32'd0);
      chk("idle_sum", 32'(rsum[0]), 32'd0);
      chk("idle_id", 32'(rid[0]), 32'd0);
      tick();
    end

    // Single requester 1
    req[0] = 3'b010;
    a_flat[0][16 +: 16] = 16'h1234;
    b_flat[0][16 +: 16] = 16'h0002;
    @(negedge clk);
    chk("single_gnt", 32'(gnt[0]), 32'h2);
    tick();
    req[0] = 3'b000;
    @(negedge clk);
    chk("single_valid", 32'(rv[0]), 32'd1);
    chk("single_id", 32'(rid[0]), 32'd1);
    chk("single_sum", 32'(rsum[0]), 32'h1236);
    chk("single_cout", 32'(rcout[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("single_drop", 32'(rv[0]), 32'd0);
    chk("single_hold", 32'(rsum[0]), 32'h1236);
    tick();

    // Pure round-robin, all three requesting
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a_flat[1][i*16 +: 16] = 16'(16'h0100 * (i + 1));
      b_flat[1][i*16 +: 16] = 16'(i);
    end
    req[1] = 3'b111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rr_gnt", 32'(gnt[1]), 32'd1 << ord3[c]);
      if (c > 0) begin
        chk("rr_valid", 32'(rv[1]), 32'd1);
        chk("rr_id", 32'(rid[1]), 32'(ord3[c-1]));
      end
      tick();
    end
    req[1] = 3'b000;
    @(negedge clk);
    chk("rr_last_id", 32'(rid[1]), 32'd2);
    chk("rr_last_sum", 32'(rsum[1]), 32'h0302);
    tick();

    // PC priority bounded by MAX_WAIT
    do_reset();
    a_flat[0] = {16'h0030, 16'h0020, 16'h0010};
    b_flat[0] = {16'h0003, 16'h0002, 16'h0001};
    cin[0]    = 3'b000;
    req[0]    = 3'b101;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("pri_gnt", 32'(gnt[0]), 32'd1 << ord4[c]);
      tick();
    end
    req[0] = 3'b000;
    @(negedge clk);
    chk("pri_last_sum", 32'(rsum[0]), 32'h0033);
    tick();

    // Overflow on requester 0, back to back
    req[0] = 3'b001;
    a_flat[0][15:0] = 16'hFFFF;
    b_flat[0][15:0] = 16'h0000;
    cin[0] = 3'b001;
    @(negedge clk);
    chk("ovf_gnt", 32'(gnt[0]), 32'd1);
    tick();
    a_flat[0][15:0] = 16'h8000;
    b_flat[0][15:0] = 16'h8000;
    cin[0] = 3'b000;
    @(negedge clk);
    chk("ovf1_sum", 32'(rsum[0]), 32'h0000);
    chk("ovf1_cout", 32'(rcout[0]), 32'd1);
    tick();
    req[0] = 3'b000;
    @(negedge clk);
    chk("ovf2_valid", 32'(rv[0]), 32'd1);
    chk("ovf2_sum", 32'(rsum[0]), 32'h0000);
    chk("ovf2_cout", 32'(rcout[0]), 32'd1);
    tick();

    // Reset pulse mid-operation restarts the pointer
    do_reset();
    a_flat[0] = {16'h0005, 16'h0004, 16'h0000};
    b_flat[0] = {16'h0001, 16'h0001, 16'h0000};
    req[0] = 3'b110;
    @(negedge clk);
    chk("rst_first_gnt", 32'(gnt[0]), 32'h2);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_gnt_zero", 32'(gnt[0]), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid_low", 32'(rv[0]), 32'd0);
    chk("rst_restart_gnt", 32'(gnt[0]), 32'h2);
    tick();
    req[0] = 3'b000;
    @(negedge clk);
    chk("rst_after_id", 32'(rid[0]), 32'd1);
    chk("rst_after_sum", 32'(rsum[0]), 32'h0005);
    tick();

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_adder_arbiter.md
Name: pc_adder_arbiter

Overview:
- Time-shares one 16-bit adder between up to NREQ requesters (requester 0 = PC increment/branch path, others = branch-target and address calculation).
- Grants at most one requester per cycle, round-robin, with optional PC priority bounded by a starvation limit.
- Registers the selected sum with a requester tag, so results appear one cycle after grant.

Parameters:
- WIDTH, 16, operand and sum width.
- NREQ, 3, number of requesters (legal range 2..4).
- PC_PRIORITY, 1, when 1 requester 0 wins over all others (bounded by MAX_WAIT); when 0 pure round-robin.
- MAX_WAIT, 3, maximum consecutive priority grants to requester 0 while any other requester waits (legal 1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request; held high with stable operands until granted.
- a_flat  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- b_flat  input  NREQ*WIDTH  operand B, same packing.
- cin  input  NREQ  per-requester carry-in.
- gnt  output  NREQ  one-hot grant, combinational, same cycle as req.
- res_valid  output  1  registered result valid.
- res_id  output  2  index of requester owning the result.
- res_sum  output  WIDTH  (A+B+cin) mod 2^WIDTH.
- res_cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- One clock domain. Reset is synchronous and active-high and applies on the clk edge where it is high.
- Reset state:
  - Round-robin pointer ptr=0, starve_cnt=0.
  - res_valid=0, res_id=0, res_sum=0, res_cout=0.
  - gnt is forced to all-zero while reset is high.
- Grant rules (combinational, evaluated every cycle):
  - req==0 -> gnt=0.
  - PC_PRIORITY=1, req[0]=1, starve_cnt<MAX_WAIT -> gnt[0]=1.
  - Otherwise, search indices ptr, ptr+1, ... with wrap modulo NREQ. Grant the first with req=1.
  - When starve_cnt==MAX_WAIT, requester 0 is masked out of this search for that cycle. If no other requester is pending, requester 0 is still granted.
  - Exactly one gnt bit is high whenever any eligible req is high.
- Transfer: a transfer occurs when req[i]&gnt[i]. Requester i may drop or change req/operands on the following cycle.
- Pointer: on any transfer of index i, ptr <= (i+1) mod NREQ. With no transfer, ptr holds.
- Starvation counter:
  - Increments when requester 0 is granted while any req[j] (j!=0) is high.
  - Clears when any j!=0 is granted, or when requester 0 is granted with no other requester pending.
  - Saturates at MAX_WAIT. Unused when PC_PRIORITY=0.
- Arithmetic: {cout,sum} = A+B+cin computed at WIDTH+1 bits on the granted operands. Combinational within the grant cycle.
- Result register (latency 1):
  - Edge after a transfer: res_valid<=1, res_id<=i, res_sum/res_cout <= the computed values.
  - Edge with no transfer: res_valid<=0. res_id, res_sum and res_cout hold their last values.
  - Back-to-back transfers give res_valid high on consecutive cycles with no bubble.
- Wrap-around: sum overflow discards bit WIDTH into res_cout. Example: 0xFFFF+0x0001+0 -> sum 0x0000, cout 1.
- Reset mid-operation: a request pending when reset rises is dropped with no result. A transfer in the cycle reset is high cannot occur because gnt=0. res_valid is 0 on the edge after reset.
- Requester indices >= NREQ never appear on res_id.

Test Plan:
- Reset then req=3'b000 for 5 cycles -> gnt=0 every cycle; res_valid=0; res_sum=0, res_id=0.
- Single requester 1: A=0x1234, B=0x0002, cin=0, one cycle -> gnt=3'b010 same cycle; next cycle res_valid=1, res_id=1, res_sum=0x1236, res_cout=0; following cycle res_valid=0, res_sum holds 0x1236.
- PC_PRIORITY=0, req=3'b111 held 6 cycles from reset -> grant order 0,1,2,0,1,2; res_id lags by one cycle with res_valid continuously 1.
- PC_PRIORITY=1, MAX_WAIT=3, req=3'b101 held -> grants 0,0,0,2,0,0,0,2; starve_cnt reaches 3 before each grant to 2.
- Requester 0 overflow: A=0xFFFF, B=0x0000, cin=1 -> res_sum=0x0000, res_cout=1; A=0x8000, B=0x8000, cin=0 -> res_sum=0x0000, res_cout=1.
- req=3'b110 held, reset pulsed high for 1 cycle after the first grant -> gnt=0 during reset; res_valid=0 the edge after; ptr restarts at 0, so the next grant goes to 1.
